spi_byte_slave: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0) slave byte engine: deserialises MOSI into bytes and

---
 rtl/spi_byte_slave.sv | 167 ++++++++++++++++
 tb/tb_spi_byte_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: SPI mode-0 (CPOL=0, CPHA=0) slave byte engine.
//   Deserialises mosi into WIDTH-bit words and serialises a host-supplied word
//   onto miso, MSB first. All SPI inputs are already registered onto clk by the
//   pin logic; mclk is oversampled and its edges are detected here.
// Ports:
//   clk      system clock (>= 3 clk per mclk phase)
//   rst_n    asynchronous active-low reset
//   select   slave select, active high, synchronous to clk
//   mclk     SPI clock, synchronous to clk
//   mosi     master-out data, synchronous to clk
//   miso     slave-out data, MSB of the transmit shifter
//   din      next word to send, sampled on select assert and on the first fall
//            after a completed word
//   dout     last complete received word, held until the next completion
//   request  1-cycle pulse: dout updated, host must present the next din
//   aborted  1-cycle pulse: select dropped in the middle of a word
module spi_byte_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             select,
  input  logic             mclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             request,
  output logic             aborted
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic             mclk_q;
  // Only the low WIDTH-1 bits of the receive shifter are ever read: the
  // completed word is formed from them plus the final mosi bit.
  logic [WIDTH-2:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             load_pending_q, load_pending_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             request_q, request_d;
  logic             aborted_q, aborted_d;

  logic rise_s;
  logic fall_s;

  assign rise_s = mclk & ~mclk_q;
  assign fall_s = ~mclk & mclk_q;

  // State register: IDLE/ACTIVE simply tracks the previous select value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (select) state_d = ST_ACTIVE;
        else        state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (!select) state_d = ST_IDLE;
        else         state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath/output logic. Select transitions take priority over any
  // coincident mclk edge; while idle only the mclk history moves.
  always_comb begin
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    bitcnt_d       = bitcnt_q;
    load_pending_d = load_pending_q;
    dout_d         = dout_q;
    request_d      = 1'b0;
    aborted_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (select) begin
          tx_sr_d        = din;
          bitcnt_d       = {CW{1'b0}};
          load_pending_d = 1'b0;
        end else begin
          tx_sr_d = tx_sr_q;
        end
      end
      ST_ACTIVE: begin
        if (!select) begin
          bitcnt_d       = {CW{1'b0}};
          load_pending_d = 1'b0;
          aborted_d      = (bitcnt_q != {CW{1'b0}});
        end else if (rise_s) begin
          rx_sr_d = {rx_sr_q[WIDTH-3:0], mosi};
          if (bitcnt_q == LAST_BIT) begin
            dout_d         = {rx_sr_q, mosi};
            bitcnt_d       = {CW{1'b0}};
            load_pending_d = 1'b1;
            request_d      = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end else if (fall_s) begin
          // The first fall after a completed word loads the next reply so its
          // MSB is on miso before the following rise.
          if (load_pending_q) begin
            tx_sr_d        = din;
            load_pending_d = 1'b0;
          end else begin
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          tx_sr_d = tx_sr_q;
        end
      end
      default: begin
        bitcnt_d       = {CW{1'b0}};
        load_pending_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; mclk history is tracked even while deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_q         <= 1'b0;
      rx_sr_q        <= {(WIDTH-1){1'b0}};
      tx_sr_q        <= {WIDTH{1'b0}};
      bitcnt_q       <= {CW{1'b0}};
      load_pending_q <= 1'b0;
      dout_q         <= {WIDTH{1'b0}};
      request_q      <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      mclk_q         <= mclk;
      rx_sr_q        <= rx_sr_d;
      tx_sr_q        <= tx_sr_d;
      bitcnt_q       <= bitcnt_d;
      load_pending_q <= load_pending_d;
      dout_q         <= dout_d;
      request_q      <= request_d;
      aborted_q      <= aborted_d;
    end
  end

  assign miso    = tx_sr_q[WIDTH-1];
  assign dout    = dout_q;
  assign request = request_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// tb_spi_byte_slave: self-checking bench for spi_byte_slave (WIDTH=8).
//   Directed table of transactions, hand-written corner sequences (deselected
//   noise, reset in mid-word) and randomized transactions. The reference is a
//   word-level model: each full word sent on mosi must appear on dout with one
//   request pulse, each reply word must appear MSB first on miso at the rises,
//   and a partial word must give one aborted pulse and leave dout alone.
module tb_spi_byte_slave;

  localparam int W  = 8;
  localparam int PH = 4;   // clk cycles per mclk phase

  logic         clk;
  logic         rst_n;
  logic         select;
  logic         mclk;
  logic         mosi;
  logic         miso;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         request;
  logic         aborted;

  spi_byte_slave #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .select  (select),
    .mclk    (mclk),
    .mosi    (mosi),
    .miso    (miso),
    .din     (din),
    .dout    (dout),
    .request (request),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int abt_cnt = 0;

  // Word-level model state.
  logic [W-1:0] exp_dout;
  logic [W-1:0] mo_words [8];
  logic [W-1:0] tx_words [8];
  int           next_tx;

  typedef struct {
    string        name;
    int           nw;
    int           pbits;
    logic [W-1:0] m0, m1, m2;
    logic [W-1:0] t0, t1, t2;
    logic [W-1:0] exp_final;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: sample after the edge, count pulses, act as the host.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (request) req_cnt++;
      if (aborted) abt_cnt++;
      if (request || aborted) check("req_abt_exclusive", {31'd0, request & aborted}, 32'd0);
      if (request) begin
        if (next_tx < 8) din = tx_words[next_tx];
        else             din = 8'($urandom);
        next_tx++;
      end
    end
  endtask

  // Master sends n bits of b (MSB first), checks miso against txb before each rise.
  task automatic send_bits(input logic [W-1:0] b, input int n, input logic [W-1:0] txb,
                           input bit full, input string tag);
    for (int i = 0; i < n; i++) begin
      mosi = b[W-1-i];
      cyc(PH);
      check({tag, "_miso"}, {31'd0, miso}, {31'd0, txb[W-1-i]});
      mclk = 1'b1;
      cyc(1);
      check({tag, "_req_timing"}, {31'd0, request}, {31'd0, (full && i == W-1)});
      cyc(PH-1);
      mclk = 1'b0;
    end
  endtask

  // Full transaction: nw complete words, then pbits of a partial word, then deselect.
  task automatic run_txn(input int nw, input int pbits, input string tag);
    int r0, a0;
    din     = tx_words[0];
    next_tx = 1;
    cyc(2);
    r0 = req_cnt;
    a0 = abt_cnt;
    select = 1'b1;
    cyc(PH);
    for (int w = 0; w < nw; w++) begin
      send_bits(mo_words[w], W, tx_words[w], 1'b1, tag);
      exp_dout = mo_words[w];
      check({tag, "_dout_word"}, {24'd0, dout}, {24'd0, exp_dout});
    end
    if (pbits > 0) send_bits(mo_words[nw], pbits, tx_words[nw], 1'b0, tag);
    cyc(PH);
    select = 1'b0;
    cyc(3);
    check({tag, "_req_count"}, req_cnt - r0, nw);
    check({tag, "_abt_count"}, abt_cnt - a0, (pbits > 0) ? 1 : 0);
    check({tag, "_dout_held"}, {24'd0, dout}, {24'd0, exp_dout});
  endtask

  initial begin
    logic [W-1:0] miso_before;
    logic [W-1:0] dout_before;
    int r0, a0;

    rst_n = 1'b0; select = 1'b0; mclk = 1'b0; mosi = 1'b0; din = 8'h00;
    next_tx = 0;
    exp_dout = 8'h00;
    cyc(3);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_request", {31'd0, request}, 32'd0);
    check("reset_aborted", {31'd0, aborted}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Directed table.
    vecs[0] = '{"single",   1, 0, 8'h3C, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h3C};
    vecs[1] = '{"b2b",      2, 0, 8'h11, 8'h22, 8'h00, 8'hC7, 8'h5A, 8'h00, 8'h22};
    vecs[2] = '{"abort",    0, 5, 8'hE6, 8'h00, 8'h00, 8'h99, 8'h00, 8'h00, 8'h22};
    vecs[3] = '{"restart",  1, 0, 8'h81, 8'h00, 8'h00, 8'h3E, 8'h00, 8'h00, 8'h81};
    for (int v = 0; v < 4; v++) begin
      mo_words[0] = vecs[v].m0; mo_words[1] = vecs[v].m1; mo_words[2] = vecs[v].m2;
      tx_words[0] = vecs[v].t0; tx_words[1] = vecs[v].t1; tx_words[2] = vecs[v].t2;
      for (int k = 3; k < 8; k++) begin
        mo_words[k] = 8'h00;
        tx_words[k] = 8'h00;
      end
      run_txn(vecs[v].nw, vecs[v].pbits, vecs[v].name);
      check({vecs[v].name, "_final"}, {24'd0, dout}, {24'd0, vecs[v].exp_final});
    end

    // Deselected noise: nothing may change except the mclk history.
    miso_before = {7'd0, miso};
    dout_before = dout;
    r0 = req_cnt;
    a0 = abt_cnt;
    for (int t = 0; t < 20; t++) begin
      mclk = ~mclk;
      mosi = 1'($urandom);
      cyc(2);
    end
    check("noise_req", req_cnt - r0, 0);
    check("noise_abt", abt_cnt - a0, 0);
    check("noise_dout", {24'd0, dout}, {24'd0, dout_before});
    check("noise_miso", {31'd0, miso}, {24'd0, miso_before});
    // Select asserted together with an mclk fall: the fall must not shift.
    mclk = 1'b1;
    cyc(PH);
    din = 8'h6B;
    tx_words[0] = 8'h6B;
    tx_words[1] = 8'h00;
    next_tx = 1;
    r0 = req_cnt;
    select = 1'b1;
    mclk = 1'b0;
    send_bits(8'h96, W, 8'h6B, 1'b1, "sel_on_fall");
    exp_dout = 8'h96;
    check("sel_on_fall_dout", {24'd0, dout}, {24'd0, exp_dout});
    check("sel_on_fall_req", req_cnt - r0, 1);
    cyc(PH);
    select = 1'b0;
    cyc(3);

    // Reset in mid-word, then a full word with select still high.
    din = 8'hFF;
    next_tx = 8;
    select = 1'b1;
    cyc(PH);
    send_bits(8'h5C, 3, 8'hFF, 1'b0, "pre_reset");
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_miso", {31'd0, miso}, 32'd0);
    check("midreset_dout", {24'd0, dout}, 32'd0);
    check("midreset_request", {31'd0, request}, 32'd0);
    check("midreset_aborted", {31'd0, aborted}, 32'd0);
    exp_dout = 8'h00;
    din = 8'hD2;
    cyc(2);
    rst_n = 1'b1;
    r0 = req_cnt;
    cyc(PH);
    send_bits(8'hF0, W, 8'hD2, 1'b1, "post_reset");
    exp_dout = 8'hF0;
    check("post_reset_dout", {24'd0, dout}, {24'd0, exp_dout});
    check("post_reset_req", req_cnt - r0, 1);
    cyc(PH);
    select = 1'b0;
    cyc(3);

    // Randomized transactions against the word-level model.
    for (int n = 0; n < 30; n++) begin
      int nw, pb;
      nw = $urandom_range(1, 3);
      pb = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, W-1);
      for (int k = 0; k < 8; k++) begin
        mo_words[k] = 8'($urandom);
        tx_words[k] = 8'($urandom);
      end
      run_txn(nw, pb, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
